cpu_clk_ctrl: RTL and testbench
===============================

Name: cpu_clk_ctrl

Overview:
Run/step/halt controller for the CPU clock on the FPGA board. It replaces a free-running fixed divider with a sequenced clock-enable: a programmable divide in RUN, one pulse per debounced button press in STEP, and a frozen CPU in HALT. A PC breakpoint stops RUN automatically. The core consumes cpu_ce_o as its clock enable; slow_clk_o drives a board LED for visual cadence.

Parameters:
DIV_W, 31, width of divide value and divide counter
DB_CYCLES, 1000000, consecutive stable cycles required to accept a button level
CNT_W, 16, width of the executed-step counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active low (rst == `RstEnable, `RstEnable = 1'b0)
mode_i  in  2  00 halt, 01 run, 10 step, 11 halt
div_i  in  DIV_W  enable period in RUN, in clk cycles; 0 treated as 1
step_btn_i  in  1  raw asynchronous step button, active high
bp_en_i  in  1  breakpoint enable
bp_addr_i  in  32  breakpoint PC
pc_i  in  32  current CPU PC
cpu_ce_o  out  1  one-cycle CPU clock enable
slow_clk_o  out  1  toggles on every RUN tick (LED)
halted_o  out  1  high in HALT and BRK states
step_cnt_o  out  CNT_W  count of issued cpu_ce_o pulses, wraps

Behaviour:
- Reset (rst low at a clk edge): state HALT; cpu_ce_o=0, slow_clk_o=0, halted_o=1, step_cnt_o=0; divide counter, debounce counter, synchroniser and debounced level all 0. Reset mid-pulse kills the pulse the next cycle.
- Button path: 2-flop synchroniser -> debouncer. The debounced level takes the synced value once that value differs from it for DB_CYCLES consecutive cycles; any bounce restarts the count. step_evt = one-cycle pulse on the debounced 0->1 edge. Releasing never generates an event.
- Divider: active only in RUN; cnt increments each cycle; when cnt == max(div_i,1)-1, tick=1 and cnt<=0. Leaving RUN clears cnt. A div_i change takes effect at the next compare; if cnt already >= new div-1, tick on the next cycle and wrap.
- FSM states: HALT, RUN, STEP, BRK.
  - HALT: mode 01 -> RUN; 10 -> STEP; else stay.
  - RUN: mode != 01 -> decoded state (00/11 HALT, 10 STEP), no pulse that cycle. On tick: if bp_en_i && pc_i == bp_addr_i -> BRK, pulse suppressed; else cpu_ce_o=1 next cycle and slow_clk_o toggles.
  - STEP: step_evt -> cpu_ce_o=1 next cycle. Mode 01 -> RUN; 00/11 -> HALT.
  - BRK: stays while mode == 01; step_evt issues one pulse (step past breakpoint) and stays BRK. Mode != 01 -> decoded state. Re-entering RUN needs mode to leave 01 and return.
- Simultaneous mode change and tick/step_evt in one cycle: the mode change wins and no pulse is issued.
- cpu_ce_o is registered, high exactly one cycle. Latency is 1 clk from the tick or step_evt cycle. Maximum rate in RUN with div 1 is every cycle.
- step_cnt_o increments in the cycle after each cpu_ce_o high and wraps 2^CNT_W-1 -> 0.
- halted_o is registered from the state: 1 in HALT/BRK, 0 in RUN/STEP.

Decomposition:
- Add to defines.v: mode encodings (`ModeHalt 2'b00, `ModeRun 2'b01, `ModeStep 2'b10) and FSM state encodings. Reuse `RstEnable.
- One sub-module, btn_debounce (synchroniser + debouncer + edge pulse, parameter DB_CYCLES), instantiated once.

Test Plan (DB_CYCLES=4 override):
- Reset, then mode=01, div_i=4, bp_en=0 -> cpu_ce_o high on cycles 4,8,12 after entry; slow_clk_o toggles each pulse; after 3 pulses step_cnt_o=3, halted_o=0.
- mode=10, step_btn bounces 1,0,1 then held 1 for 6 cycles -> exactly one cpu_ce_o pulse, 1 cycle after debounced edge (sync+4 cycles). Release produces no pulse.
- RUN div=2, bp_en=1, bp_addr=0x10, pc_i=0x10 at tick -> no pulse, halted_o=1 (BRK). Step press -> exactly one pulse, still BRK. mode 01->00->01 -> RUN resumes.
- RUN div=4, mode -> 00 on the same cycle as tick -> no pulse, HALT, divider cleared. Re-enter RUN -> first pulse 4 cycles later.
- div_i=0 in RUN -> cpu_ce_o high every cycle. step_cnt_o preset by 65535 pulses then one more -> wraps to 0.
- rst low during RUN on the cycle cpu_ce_o is high -> next cycle all outputs at reset values, halted_o=1, state HALT.

Source files
------------

// File: rtl/cpu_clk_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clk_ctrl_pkg
// Brief    : Mode/state encodings and helpers for the CPU clock controller.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_clk_ctrl_pkg;

  typedef logic [1:0] mode_t;
  typedef logic [1:0] state_t;

  localparam logic RST_ENABLE = 1'b0;

  localparam mode_t MODE_HALT = 2'b00;
  localparam mode_t MODE_RUN  = 2'b01;
  localparam mode_t MODE_STEP = 2'b10;

  localparam state_t ST_HALT = 2'b00;
  localparam state_t ST_RUN  = 2'b01;
  localparam state_t ST_STEP = 2'b10;
  localparam state_t ST_BRK  = 2'b11;

  // Mode 11 is reserved and behaves as halt.
  function automatic state_t decode_mode(input mode_t mode);
    case (mode)
      MODE_RUN:  return ST_RUN;
      MODE_STEP: return ST_STEP;
      default:   return ST_HALT;
    endcase
  endfunction

  function automatic logic is_halted(input state_t st);
    return (st == ST_HALT) || (st == ST_BRK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : 2-flop synchroniser, counting debouncer, rising-edge event pulse.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic evt_o
);

  localparam int            DB_W    = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            level_q, level_d;
  logic            level_dly_q, level_dly_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  // Any cycle where the synced value matches the level restarts the count.
  always_comb begin
    sync1_d     = btn_i;
    sync2_d     = sync1_q;
    level_d     = level_q;
    level_dly_d = level_q;
    db_cnt_d    = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      db_cnt_q    <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      db_cnt_q    <= db_cnt_d;
    end
  end

  assign evt_o = level_q & ~level_dly_q;

endmodule
`default_nettype wire

// File: rtl/cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clk_ctrl
// Brief    : Run/step/halt CPU clock-enable sequencer with PC breakpoint.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DIV_W     = 31,
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             step_btn_i,
  input  logic             bp_en_i,
  input  logic [31:0]      bp_addr_i,
  input  logic [31:0]      pc_i,
  output logic             cpu_ce_o,
  output logic             slow_clk_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] step_cnt_o
);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             ce_q, ce_d;
  logic             slow_q, slow_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

  logic             step_evt;
  logic             run_hold;
  logic             tick;
  logic             bp_hit;
  logic [DIV_W-1:0] div_last;
  state_t           mode_state;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn_i (step_btn_i),
    .evt_o (step_evt)
  );

  // >= rather than == so a shrinking div_i wraps on the very next cycle.
  assign div_last   = (div_i == '0) ? '0 : div_i - DIV_W'(1);
  assign run_hold   = (state_q == ST_RUN) && (mode_i == MODE_RUN);
  assign tick       = run_hold && (div_cnt_q >= div_last);
  assign bp_hit     = bp_en_i && (pc_i == bp_addr_i);
  assign mode_state = decode_mode(mode_i);

  always_comb begin
    div_cnt_d = (run_hold && !tick) ? div_cnt_q + DIV_W'(1) : '0;
  end

  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    slow_d  = slow_q;
    case (state_q)
      ST_HALT: state_d = mode_state;
      ST_RUN: begin
        if (mode_state != ST_RUN) begin
          state_d = mode_state;
        end else if (tick) begin
          if (bp_hit) begin
            state_d = ST_BRK;
          end else begin
            ce_d   = 1'b1;
            slow_d = ~slow_q;
          end
        end
      end
      ST_STEP: begin
        if (mode_state != ST_STEP) state_d = mode_state;
        else                       ce_d    = step_evt;
      end
      default: begin
        // Held in BRK while mode stays RUN; the button steps past the breakpoint.
        if (mode_state != ST_RUN) state_d = mode_state;
        else                      ce_d    = step_evt;
      end
    endcase
    halted_d   = is_halted(state_d);
    step_cnt_d = step_cnt_q + CNT_W'(ce_q);
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= ST_HALT;
      div_cnt_q  <= '0;
      ce_q       <= 1'b0;
      slow_q     <= 1'b0;
      halted_q   <= 1'b1;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      ce_q       <= ce_d;
      slow_q     <= slow_d;
      halted_q   <= halted_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign cpu_ce_o   = ce_q;
  assign slow_clk_o = slow_q;
  assign halted_o   = halted_q;
  assign step_cnt_o = step_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_clk_ctrl
// Brief    : Self-checking bench for cpu_clk_ctrl with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_clk_ctrl;

  localparam int DB = 4;

  logic        clk        = 1'b0;
  logic        rst        = 1'b0;
  logic [1:0]  mode       = 2'b00;
  logic [30:0] div        = 31'd1;
  logic        btn        = 1'b0;
  logic        bp_en      = 1'b0;
  logic [31:0] bp_addr    = 32'h0;
  logic [31:0] pc         = 32'h0;
  logic        cpu_ce_o;
  logic        slow_clk_o;
  logic        halted_o;
  logic [15:0] step_cnt_o;

  int vectors     = 0;
  int miscompares = 0;

  cpu_clk_ctrl #(
    .DIV_W     (31),
    .DB_CYCLES (DB),
    .CNT_W     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_i     (mode),
    .div_i      (div),
    .step_btn_i (btn),
    .bp_en_i    (bp_en),
    .bp_addr_i  (bp_addr),
    .pc_i       (pc),
    .cpu_ce_o   (cpu_ce_o),
    .slow_clk_o (slow_clk_o),
    .halted_o   (halted_o),
    .step_cnt_o (step_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: what the controller is supposed to be doing, per cycle.
  typedef enum int {M_HALT, M_RUN, M_STEP, M_BRK} mstate_t;
  typedef struct {
    mstate_t     st;
    int unsigned elapsed;   // RUN cycles since entry or last tick
    bit          ce, slow, halted;
    bit [15:0]   cnt;
    bit          raw1, raw2, lvl, lvl_prev;
    int unsigned stable;
  } model_t;

  model_t m;

  function automatic mstate_t wanted(input logic [1:0] md);
    if (md == 2'b01) return M_RUN;
    if (md == 2'b10) return M_STEP;
    return M_HALT;
  endfunction

  function automatic model_t model_next(input model_t cur, input logic rn, input logic [1:0] md,
                                        input logic [30:0] dv, input logic b, input logic be,
                                        input logic [31:0] ba, input logic [31:0] p);
    model_t      n;
    bit          evt;
    int unsigned period;
    mstate_t     w;
    n = cur;
    if (!rn) begin
      n.st = M_HALT; n.elapsed = 0; n.ce = 0; n.slow = 0; n.halted = 1; n.cnt = 0;
      n.raw1 = 0; n.raw2 = 0; n.lvl = 0; n.lvl_prev = 0; n.stable = 0;
      return n;
    end
    n.raw1 = b;
    n.raw2 = cur.raw1;
    n.stable = 0;
    if (cur.raw2 != cur.lvl) begin
      if (cur.stable + 1 >= DB) n.lvl = cur.raw2;
      else                      n.stable = cur.stable + 1;
    end
    n.lvl_prev = cur.lvl;
    evt    = cur.lvl && !cur.lvl_prev;
    period = (dv == 0) ? 1 : int'(dv);
    w      = wanted(md);
    n.ce   = 0;
    n.elapsed = 0;
    n.cnt  = cur.cnt + 16'(cur.ce);
    case (cur.st)
      M_HALT: n.st = w;
      M_RUN: begin
        if (w != M_RUN) n.st = w;
        else if (cur.elapsed + 1 >= period) begin
          if (be && p == ba) n.st = M_BRK;
          else begin n.ce = 1; n.slow = !cur.slow; end
        end else n.elapsed = cur.elapsed + 1;
      end
      M_STEP: if (w != M_STEP) n.st = w; else n.ce = evt;
      M_BRK:  if (w != M_RUN) n.st = w; else n.ce = evt;
      default: n.st = M_HALT;
    endcase
    n.halted = (n.st == M_HALT) || (n.st == M_BRK);
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, rst, mode, div, btn, bp_en, bp_addr, pc);

  wire  [18:0] dut_obs = {cpu_ce_o, slow_clk_o, halted_o, step_cnt_o};
  logic [18:0] exp_obs;
  always_comb exp_obs = {m.ce, m.slow, m.halted, m.cnt};

  task automatic test_reset();
    rst = 1'b0; mode = 2'b00; div = 31'd1; btn = 1'b0; bp_en = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (dut_obs !== {1'b0, 1'b0, 1'b1, 16'h0}) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", dut_obs, {1'b0, 1'b0, 1'b1, 16'h0});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (dut_obs !== exp_obs) begin
      miscompares++;
      $display("FAIL reset_release: got %h want %h", dut_obs, exp_obs);
    end
  endtask

  task automatic test_run_div4();
    int hits[$];
    mode = 2'b01; div = 31'd4; bp_en = 1'b0; pc = 32'h0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      vectors++;
      if (dut_obs !== exp_obs) begin
        miscompares++;
        $display("FAIL run_div4 cyc %0d: got %h want %h", k, dut_obs, exp_obs);
      end
      if (cpu_ce_o) hits.push_back(k);
    end
    // Edge 1 enters RUN, so pulses follow edges 5, 9, 13 (4, 8, 12 after entry).
    vectors++;
    if (hits.size() != 3 || hits[0] != 5 || hits[1] != 9 || hits[2] != 13) begin
      miscompares++;
      $display("FAIL run_div4_timing: got %0d pulses first=%0d want 3 pulses at 5,9,13",
               hits.size(), (hits.size() > 0) ? hits[0] : -1);
    end
    vectors++;
    if ({slow_clk_o, halted_o, step_cnt_o} !== {1'b1, 1'b0, 16'd3}) begin
      miscompares++;
      $display("FAIL run_div4_status: got slow=%b halted=%b cnt=%0d want 1 0 3",
               slow_clk_o, halted_o, step_cnt_o);
    end
  endtask

  task automatic test_step_debounce();
    bit pat [23];
    int pulses = 0;
    int first  = -1;
    mode = 2'b10;
    repeat (3) @(negedge clk);
    foreach (pat[i]) pat[i] = (i == 0) || (i >= 2 && i <= 8);
    for (int i = 0; i < 23; i++) begin
      btn = pat[i];
      @(negedge clk);
      vectors++;
      if (dut_obs !== exp_obs) begin
        miscompares++;
        $display("FAIL step_debounce cyc %0d: got %h want %h", i, dut_obs, exp_obs);
      end
      if (cpu_ce_o) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    // Level accepted on edge 8, event seen there, pulse registered on edge 9.
    vectors++;
    if (pulses != 1 || first != 8) begin
      miscompares++;
      $display("FAIL step_single_pulse: got %0d pulses at %0d want 1 at 8", pulses, first);
    end
  endtask

  task automatic test_breakpoint();
    int pulses = 0;
    btn = 1'b0; bp_en = 1'b1; bp_addr = 32'h10; pc = 32'h10; div = 31'd2; mode = 2'b01;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_obs !== exp_obs) begin
        miscompares++;
        $display("FAIL bp_hit cyc %0d: got %h want %h", i, dut_obs, exp_obs);
      end
      if (cpu_ce_o) pulses++;
    end
    vectors++;
    if (pulses != 0 || halted_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_stop: got pulses=%0d halted=%b want 0 1", pulses, halted_o);
    end
    for (int i = 0; i < 20; i++) begin
      btn = (i < 8);
      @(negedge clk);
      vectors++;
      if (dut_obs !== exp_obs) begin
        miscompares++;
        $display("FAIL bp_step cyc %0d: got %h want %h", i, dut_obs, exp_obs);
      end
      if (cpu_ce_o) pulses++;
    end
    vectors++;
    if (pulses != 1 || halted_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_step_past: got pulses=%0d halted=%b want 1 1", pulses, halted_o);
    end
    mode = 2'b00;
    repeat (2) @(negedge clk);
    pc = 32'h20; mode = 2'b01; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_obs !== exp_obs) begin
        miscompares++;
        $display("FAIL bp_resume cyc %0d: got %h want %h", i, dut_obs, exp_obs);
      end
      if (cpu_ce_o) pulses++;
    end
    vectors++;
    if (pulses != 4 || halted_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_resume_run: got pulses=%0d halted=%b want 4 0", pulses, halted_o);
    end
  endtask

  task automatic test_mode_vs_tick();
    int first = -1;
    bp_en = 1'b0; mode = 2'b00;
    repeat (2) @(negedge clk);
    div = 31'd4; mode = 2'b01;
    repeat (4) @(negedge clk);
    mode = 2'b00;   // lands on the tick edge
    @(negedge clk);
    vectors++;
    if ({cpu_ce_o, halted_o} !== 2'b01 || dut_obs !== exp_obs) begin
      miscompares++;
      $display("FAIL mode_wins: got ce=%b halted=%b (%h) want ce=0 halted=1 (%h)",
               cpu_ce_o, halted_o, dut_obs, exp_obs);
    end
    mode = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      vectors++;
      if (dut_obs !== exp_obs) begin
        miscompares++;
        $display("FAIL reenter_run cyc %0d: got %h want %h", k, dut_obs, exp_obs);
      end
      if (cpu_ce_o && first < 0) first = k;
    end
    vectors++;
    if (first != 5) begin
      miscompares++;
      $display("FAIL reenter_first_pulse: got edge %0d want 5", first);
    end
  endtask

  task automatic test_div0();
    int pulses = 0;
    mode = 2'b00;
    repeat (2) @(negedge clk);
    div = 31'd0; mode = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      vectors++;
      if (dut_obs !== exp_obs) begin
        miscompares++;
        $display("FAIL div0 cyc %0d: got %h want %h", k, dut_obs, exp_obs);
      end
      if (cpu_ce_o) pulses++;
    end
    vectors++;
    if (pulses != 11) begin
      miscompares++;
      $display("FAIL div0_rate: got %0d pulses want 11", pulses);
    end
  endtask

  task automatic test_wrap();
    int pulses = 0;
    int guard  = 0;
    rst = 1'b0; mode = 2'b00;
    @(negedge clk);
    rst = 1'b1; div = 31'd1; mode = 2'b01;
    while (pulses < 65535 && guard < 70000) begin
      @(negedge clk);
      guard++;
      if (cpu_ce_o) pulses++;
    end
    vectors++;
    if (pulses != 65535) begin
      miscompares++;
      $display("FAIL wrap_budget: got %0d pulses want 65535", pulses);
    end
    @(negedge clk);
    vectors++;
    if (step_cnt_o !== 16'd65535 || dut_obs !== exp_obs) begin
      miscompares++;
      $display("FAIL wrap_full: got cnt=%0d want 65535", step_cnt_o);
    end
    mode = 2'b00;
    @(negedge clk);
    vectors++;
    if (step_cnt_o !== 16'd0 || cpu_ce_o !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_zero: got cnt=%0d ce=%b want 0 0", step_cnt_o, cpu_ce_o);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int guard = 0;
    div = 31'd3; mode = 2'b01;
    while (!cpu_ce_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (!cpu_ce_o) begin
      miscompares++;
      $display("FAIL mid_pulse_wait: got no pulse within 20 cycles want a pulse");
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (dut_obs !== {1'b0, 1'b0, 1'b1, 16'h0}) begin
      miscompares++;
      $display("FAIL reset_mid_pulse: got %h want %h", dut_obs, {1'b0, 1'b0, 1'b1, 16'h0});
    end
    rst = 1'b1; mode = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_random();
    bp_addr = 32'h10;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(19, 0) == 0) mode = 2'($urandom_range(3, 0));
      if ($urandom_range(29, 0) == 0) div = 31'($urandom_range(4, 0));
      if ($urandom_range(5, 0) == 0) btn = ~btn;
      if ($urandom_range(9, 0) == 0) bp_en = 1'($urandom_range(1, 0));
      pc  = ($urandom_range(3, 0) == 0) ? 32'h10 : 32'h14;
      rst = ($urandom_range(499, 0) != 0);
      @(negedge clk);
      vectors++;
      if (dut_obs !== exp_obs) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h want %h", i, dut_obs, exp_obs);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_run_div4();
    test_step_debounce();
    test_breakpoint();
    test_mode_vs_tick();
    test_div0();
    test_wrap();
    test_reset_mid_pulse();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
